// File: rtl/timer_set_pkg.sv
// Shared constants and BCD helpers for the timer-set datapath.
package timer_set_pkg;

  localparam int DEFAULT_TW      = 10;
  localparam int DEFAULT_MAX_MIN = 15;
  localparam int DEFAULT_MAX_SEC = 59;

  // Display select codes
  localparam logic [1:0] DISP_ENTRY = 2'b00;
  localparam logic [1:0] DISP_A     = 2'b01;
  localparam logic [1:0] DISP_B     = 2'b10;
  localparam logic [1:0] DISP_T     = 2'b11;

  // Keypad entry limits
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [1:0] ENTRY_DIGITS  = 2'd2;

  // Two packed BCD digits to binary (0..99)
  function automatic logic [6:0] bcd2_to_bin(input logic [7:0] bcd);
    return ({3'b000, bcd[7:4]} * 7'd10) + {3'b000, bcd[3:0]};
  endfunction

  // Binary to two packed BCD digits; meaningful only for values up to 99
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/timer_key_entry.sv
// Two-digit keypad entry register with digit counter, ack pulse and t decode.
module timer_key_entry
  import timer_set_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       Kc,
  input  logic       Er,
  output logic [7:0] entry,
  output logic       key_ack,
  output logic       t
);

  logic [7:0] entry_reg;
  logic [1:0] kcnt_reg;
  logic       entry_en_reg;
  logic       key_ack_reg;
  logic       accept;

  // A same-cycle clear (Kc or Er) wins over a key, which is then lost
  assign accept = key_valid && (key_code <= KEY_MAX_DIGIT) && entry_en_reg && !Kc && !Er;

  // Entry shift register, digit count and enable; entry opens only after a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_reg    <= 8'h00;
      kcnt_reg     <= 2'd0;
      entry_en_reg <= 1'b0;
      key_ack_reg  <= 1'b0;
    end else begin
      key_ack_reg <= accept;
      if (Kc || Er) begin
        entry_reg    <= 8'h00;
        kcnt_reg     <= 2'd0;
        entry_en_reg <= 1'b1;
      end else if (accept) begin
        entry_reg <= {entry_reg[3:0], key_code};
        kcnt_reg  <= kcnt_reg + 2'd1;
        // Second digit closes the entry so kcnt saturates at 2
        if (kcnt_reg == ENTRY_DIGITS - 2'd1) begin
          entry_en_reg <= 1'b0;
        end
      end
    end
  end

  assign entry   = entry_reg;
  assign key_ack = key_ack_reg;
  assign t       = (kcnt_reg == ENTRY_DIGITS);

endmodule

// File: rtl/timer_set_datapath.sv
// Timer-set datapath: minutes/seconds registers, total-seconds result and display mux.
module timer_set_datapath
  import timer_set_pkg::*;
#(
  parameter int TW      = DEFAULT_TW,
  parameter int MAX_MIN = DEFAULT_MAX_MIN,
  parameter int MAX_SEC = DEFAULT_MAX_SEC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic          key_ack,
  input  logic [1:0]    s,
  input  logic          Kc,
  input  logic          La,
  input  logic          Lb,
  input  logic          Ea,
  input  logic          Lr,
  input  logic          Er,
  output logic          t,
  output logic          k7,
  output logic [TW-1:0] T,
  output logic [7:0]    disp
);

  localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);
  localparam logic [6:0] MAX_SEC_L = 7'(MAX_SEC);

  logic [7:0]    entry;
  logic [6:0]    entry_bin;
  logic [6:0]    a_reg;
  logic [6:0]    b_reg;
  logic [TW-1:0] r_reg;
  logic [TW-1:0] t_total_reg;
  logic          k7_reg;
  logic [12:0]   sum_full;
  logic          valid;
  logic [6:0]    t_mod;
  logic          unused_r;

  timer_key_entry u_key_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .Kc        (Kc),
    .Er        (Er),
    .entry     (entry),
    .key_ack   (key_ack),
    .t         (t)
  );

  assign entry_bin = bcd2_to_bin(entry);

  // A*60 + B without a multiplier: 64A - 4A + B
  assign sum_full = ({6'b0, a_reg} << 6) - ({6'b0, a_reg} << 2) + {6'b0, b_reg};
  assign valid    = (a_reg <= MAX_MIN_L) && (b_reg <= MAX_SEC_L);

  // Operand, result and commit registers; Lr recomputes from A/B so Ea+Lr is consistent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg       <= 7'd0;
      b_reg       <= 7'd0;
      r_reg       <= '0;
      t_total_reg <= '0;
      k7_reg      <= 1'b0;
    end else begin
      if (La) a_reg <= entry_bin;
      if (Lb) b_reg <= entry_bin;
      if (Ea) r_reg <= TW'(sum_full);
      if (Lr) begin
        k7_reg <= valid;
        if (valid) t_total_reg <= TW'(sum_full);
      end else if (Kc) begin
        k7_reg <= 1'b0;
      end
    end
  end

  // R mirrors the controller's evaluate step and has no port of its own
  assign unused_r = ^r_reg;

  assign t_mod = 7'(t_total_reg % TW'(100));

  // Display source select
  always_comb begin
    disp = entry;
    case (s)
      DISP_ENTRY: disp = entry;
      DISP_A:     disp = bin_to_bcd2(a_reg);
      DISP_B:     disp = bin_to_bcd2(b_reg);
      DISP_T:     disp = bin_to_bcd2(t_mod);
      default:    disp = entry;
    endcase
  end

  assign k7 = k7_reg;
  assign T  = t_total_reg;

endmodule

// File: doc/timer_set_datapath.md
Name: timer_set_datapath

Overview:
Datapath stage directly downstream of the timer-set PLA controller. It consumes the controller's registered strobes (Kc, La, Lb, Ea, Lr, Er, s). It accepts two-digit keypad entries for minutes and seconds and converts them to a total-seconds value T. It returns the status flags t and k7 that close the controller loop.

Parameters:
TW, 10, width of T (total seconds)
MAX_MIN, 15, largest accepted minutes value
MAX_SEC, 59, largest accepted seconds value

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
key_valid  input  1  keypad key strobe, one cycle per press
key_code  input  4  key value; 0-9 are digits, 10-15 are ignored
key_ack  output  1  one-cycle pulse, the cycle after an accepted digit
s  input  2  display select: 00 entry, 01 A, 10 B, 11 T
Kc  input  1  clear entry: clear E and kcnt, set entry_en, clear k7
La  input  1  load minutes register A from entry
Lb  input  1  load seconds register B from entry
Ea  input  1  evaluate: R <= A*60+B
Lr  input  1  load result T and the validity flag k7
Er  input  1  reset entry after a load: clear E and kcnt, set entry_en
t  output  1  entry complete (kcnt==2)
k7  output  1  last Lr produced a valid time
T  output  TW  committed total seconds
disp  output  8  two BCD digits for the display, selected by s

Behaviour:
- Reset (rst_n=0 at posedge): E=0, kcnt=0, entry_en=0, A=0, B=0, R=0, T=0, k7=0, key_ack=0. Entry stays disabled until the first Kc.
- Entry register E holds two BCD digits {tens, units}.
- A digit is accepted when key_valid=1, key_code<=9, entry_en=1, and neither Kc nor Er is asserted in that cycle.
- On acceptance: E <= {E.units, key_code}; kcnt <= kcnt+1. key_ack pulses on the next cycle.
- When kcnt reaches 2, entry_en clears. Further keys are dropped with no ack. kcnt never exceeds 2.
- t = (kcnt==2), a combinational decode of the register.
- Non-digit codes and keys arriving while entry_en=0 are silently dropped (no ack, no state change).
- Kc and Er have priority over a same-cycle key; that key is lost. Kc additionally clears k7.
- La: A <= E.tens*10 + E.units (7-bit binary). Lb: B <= the same conversion into B.
- La or Lb in the same cycle as Er: the load uses the pre-clear value of E. E clears on the same edge.
- If La and Lb are both asserted, both registers load from E.
- Ea: R <= A*60 + B, computed as (A<<6)-(A<<2)+B at 13-bit internal width. R is TW bits, truncated only when invalid.
- Lr: valid = (A<=MAX_MIN) && (B<=MAX_SEC).
  - If valid: T <= A*60+B, k7 <= 1.
  - Else: T holds its old value, k7 <= 0.
- Lr recomputes from A/B directly, so Ea and Lr in the same cycle (the controller's state 6) give a consistent T.
- k7 holds until the next Lr or Kc.
- disp is combinational from s:
  - 00: E.
  - 01: A in BCD.
  - 10: B in BCD.
  - 11: T mod 100 in BCD.
  - Binary-to-BCD for A and B is valid only for values up to 99.
- Latency: strobe to register update is 1 clk. key_valid to key_ack is 1 clk.
- Reset mid-entry discards the partial digits and disables entry.

Decomposition:
- Package timer_set_pkg holds:
  - TW, MAX_MIN, MAX_SEC defaults;
  - display-select codes DISP_ENTRY, DISP_A, DISP_B, DISP_T;
  - function bcd2_to_bin.
- One natural sub-module, timer_key_entry: E, kcnt, entry_en, key_ack and the t decode. The top holds A, B, R, T, k7 and the disp mux.

Test Plan:
- Reset, then key_valid with key_code=5 before any Kc -> key_ack=0, E=00, t=0. After Kc, the same key -> key_ack=1 the next cycle, E=05.
- Kc; keys 1,2 -> t=1. A third key 7 -> no ack, E=12. La+Er -> A=12, E=00, t=0.
- Keys 3,4; Lb+Er -> B=34. Ea+Lr -> T=754, k7=1. s=11 -> disp=0x54.
- Kc; keys 1,6; La+Er; keys 0,5; Lb+Er; Ea+Lr -> k7=0, T stays 754.
- key_valid asserted in the same cycle as Kc, and again in the same cycle as Er -> key dropped, kcnt=0, no ack.
- rst_n=0 after one digit is entered -> E=0, kcnt=0, T=0, k7=0, entry_en=0.
